wr_out_arbiter: RTL and testbench
=================================

Name: wr_out_arbiter

Overview:
- Shares the single ASIC-to-FPGA write-out interface (config_paulse/config_data/config_ready plus wr_req/wr_ready/wr_data) between two producers: the flag-OFM packer (FLG) and the OFM packer (OFM).
- Grants one packet at a time with round-robin fairness.
- Issues the configuration pulse with the matching interface code, then streams exactly one packet of words.
- Waits for the write-out interface to return to idle before granting again.
- Sits between the PE-array output packers and the async write FIFO interface.

Parameters:
- SPI_WIDTH, 32, data word width.
- TX_WIDTH, 20, width of the packet word counter.
- FLG_SIZE, 64, words per FLG packet; must be ≥1 and < 2^TX_WIDTH.
- OFM_SIZE, 1024, words per OFM packet; must be ≥1 and < 2^TX_WIDTH.
- CODE_FLG, 4'd0, config_data code for a flag-OFM packet.
- CODE_OFM, 4'd1, config_data code for an OFM packet.

Ports:
- clk_chip  in  1  chip clock.
- reset_chip  in  1  reset.
- flg_req  in  1  FLG has a packet pending; level, held until flg_done.
- flg_valid  in  1  FLG data word valid.
- flg_data  in  SPI_WIDTH  FLG data word.
- flg_ready  out  1  FLG word accepted this cycle.
- flg_done  out  1  one-cycle pulse: FLG packet fully delivered.
- ofm_req  in  1  OFM packet pending; level.
- ofm_valid  in  1  OFM data word valid.
- ofm_data  in  SPI_WIDTH  OFM data word.
- ofm_ready  out  1  OFM word accepted.
- ofm_done  out  1  one-cycle pulse: OFM packet delivered.
- config_ready  in  1  write-out interface idle.
- config_paulse  out  1  one-cycle configuration pulse.
- config_data  out  4  packet type code.
- wr_ready  in  1  write-out interface can take a word.
- wr_req  out  1  word write strobe.
- wr_data  out  SPI_WIDTH  word to write.
- grant  out  2  one-hot active source: bit0 = FLG, bit1 = OFM; 0 when idle.
- busy  out  1  state != IDLE.

Behaviour:
- Single clock clk_chip; reset_chip is synchronous, active-high.
- Reset values: state IDLE, count 0, last_grant = OFM (so FLG wins the first tie), config_data 0, grant 0, and every other output 0.
- Reset mid-packet aborts immediately: outputs are 0 on the next edge and no done pulse is issued.
- States:
  - IDLE: if config_ready=1 and any req, select the source: the only requester, or on a tie the one not equal to last_grant. Register grant and config_data (CODE_FLG / CODE_OFM), clear count, go to CONFIG. If config_ready=0, stay.
  - CONFIG: config_paulse=1 for exactly this one cycle (registered output). Go to ARM.
  - ARM: wait for config_ready=0, which acknowledges that the interface has left idle; then go to STREAM. No words move in ARM.
  - STREAM:
    - size = FLG_SIZE or OFM_SIZE per grant.
    - src_ready (granted source only) = wr_ready & (count < size); combinational.
    - wr_req = src_valid & src_ready; combinational.
    - wr_data = granted source data; combinational mux; 0 when no grant.
    - count increments on each wr_req.
    - When a beat occurs with count = size-1, go to CLOSE next cycle.
    - src_ready of the non-granted source stays 0.
  - CLOSE: no data moves. Wait for config_ready=1 (interface back to idle). Then pulse the granted source's done for one cycle, set last_grant = grant, clear grant, go to IDLE.
- grant and config_data are stable from CONFIG through CLOSE.
- Latency:
  - IDLE→config_paulse: 1 cycle after the request is seen.
  - First possible wr_req: the cycle after ARM observes config_ready=0.
  - A new packet may start in IDLE on the cycle right after done.
- Boundary conditions:
  - Requests arriving or dropping outside IDLE are ignored until IDLE.
  - valid=0 or wr_ready=0 in STREAM stalls; count holds.
  - count never exceeds size. No word beyond size is accepted even if valid and wr_ready stay high.
  - size=1: a single beat moves STREAM→CLOSE.
  - Both reqs high continuously: packets alternate FLG, OFM, FLG, ...

Test Plan:
- Reset, then flg_req=1, config_ready=1, FLG_SIZE=4 -> config_paulse 1 cycle with config_data=CODE_FLG, grant=01. After config_ready drops, 4 wr_req beats carry flg_data D0..D3. Once config_ready=1, flg_done pulses once; then busy=0.
- Both reqs held high, 3 packets -> grant order 01, 10, 01. config_data alternates CODE_FLG/CODE_OFM. ofm_ready=0 throughout FLG packets and vice versa.
- STREAM with wr_ready toggled 1,0,1,0 and flg_valid gapped -> wr_req only when valid & wr_ready; count reaches exactly FLG_SIZE. No fifth beat is issued when FLG_SIZE=4 even with valid and wr_ready held high.
- config_ready held high for 5 cycles after config_paulse -> remains in ARM and no wr_req; streaming starts the cycle after config_ready=0.
- reset_chip asserted after 2 of 4 beats -> next cycle all outputs 0 and no done. A new flg_req then completes a full 4-word packet.
- FLG_SIZE=1 -> one beat, then CLOSE; done only after config_ready returns to 1 (held low 3 extra cycles -> done delayed 3 cycles).

Source files
------------

// File: rtl/wr_out_arbiter.sv
// wr_out_arbiter: round-robin share of the write-out interface between the FLG and OFM packers, one packet per grant
module wr_out_arbiter #(
  parameter int SPI_WIDTH = 32,
  parameter int TX_WIDTH = 20,
  parameter int FLG_SIZE = 64,
  parameter int OFM_SIZE = 1024,
  parameter logic [3:0] CODE_FLG = 4'd0,
  parameter logic [3:0] CODE_OFM = 4'd1
) (
  input  logic                 clk_chip,
  input  logic                 reset_chip,
  input  logic                 flg_req,
  input  logic                 flg_valid,
  input  logic [SPI_WIDTH-1:0] flg_data,
  output logic                 flg_ready,
  output logic                 flg_done,
  input  logic                 ofm_req,
  input  logic                 ofm_valid,
  input  logic [SPI_WIDTH-1:0] ofm_data,
  output logic                 ofm_ready,
  output logic                 ofm_done,
  input  logic                 config_ready,
  output logic                 config_paulse,
  output logic [3:0]           config_data,
  input  logic                 wr_ready,
  output logic                 wr_req,
  output logic [SPI_WIDTH-1:0] wr_data,
  output logic [1:0]           grant,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, CONFIG, ARM, STREAM, CLOSE} state_t;
  state_t state, state_nxt;
  logic [TX_WIDTH-1:0] count, size;
  logic last_ofm, pick_ofm, src_valid, src_ready, beat, release_grant;
  assign size = grant[1] ? TX_WIDTH'(OFM_SIZE) : TX_WIDTH'(FLG_SIZE);
  assign src_valid = grant[1] ? ofm_valid : grant[0] & flg_valid;
  assign src_ready = (state == STREAM) & wr_ready & (count < size);
  assign beat = src_valid & src_ready;
  assign flg_ready = src_ready & grant[0];
  assign ofm_ready = src_ready & grant[1];
  assign wr_req = beat;
  assign wr_data = grant[1] ? ofm_data : grant[0] ? flg_data : '0;
  assign busy = state != IDLE;
  // Done fires in the CLOSE cycle itself so the producer drops its req before IDLE samples it again.
  assign release_grant = (state == CLOSE) & config_ready;
  assign flg_done = release_grant & grant[0];
  assign ofm_done = release_grant & grant[1];
  // OFM wins when it is the sole requester, or on a tie when FLG went last.
  assign pick_ofm = ofm_req & (~flg_req | ~last_ofm);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (config_ready & (flg_req | ofm_req)) state_nxt = CONFIG;
      CONFIG:  state_nxt = ARM;
      ARM:     if (!config_ready) state_nxt = STREAM;
      STREAM:  if (beat && count == size - TX_WIDTH'(1)) state_nxt = CLOSE;
      CLOSE:   if (config_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_chip) begin
    if (reset_chip) begin
      state <= IDLE;
      count <= '0;
      last_ofm <= 1'b1;
      grant <= '0;
      config_data <= '0;
      config_paulse <= 1'b0;
    end else begin
      state <= state_nxt;
      config_paulse <= state_nxt == CONFIG;
      count <= (state == IDLE) ? '0 : count + TX_WIDTH'(beat);
      if (state == IDLE && state_nxt == CONFIG) begin
        grant <= pick_ofm ? 2'b10 : 2'b01;
        config_data <= pick_ofm ? CODE_OFM : CODE_FLG;
      end
      if (release_grant) begin
        last_ofm <= grant[1];
        grant <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wr_out_arbiter.sv
// tb_wr_out_arbiter: randomized packet-level check of wr_out_arbiter against a round-robin transaction model
module tb_wr_out_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic flg_req = 1'b0, flg_valid = 1'b0, ofm_req = 1'b0, ofm_valid = 1'b0;
  logic config_ready = 1'b0, wr_ready = 1'b0;
  logic [31:0] flg_data = '0, ofm_data = '0;
  logic flg_ready_o[2], flg_done_o[2], ofm_ready_o[2], ofm_done_o[2];
  logic paulse_o[2], wr_req_o[2], busy_o[2];
  logic [3:0] cdata_o[2];
  logic [31:0] wr_data_o[2];
  logic [1:0] grant_o[2];
  int checks = 0, errors = 0, sel = 0, last_src = 1;
  int fsz[2] = '{4, 1};
  int osz[2] = '{6, 2};
  for (genvar i = 0; i < 2; i++) begin : g_dut
    wr_out_arbiter #(.FLG_SIZE(i == 0 ? 4 : 1), .OFM_SIZE(i == 0 ? 6 : 2)) u_dut (
      .clk_chip(clk), .reset_chip(rst),
      .flg_req(flg_req), .flg_valid(flg_valid), .flg_data(flg_data),
      .flg_ready(flg_ready_o[i]), .flg_done(flg_done_o[i]),
      .ofm_req(ofm_req), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
      .ofm_ready(ofm_ready_o[i]), .ofm_done(ofm_done_o[i]),
      .config_ready(config_ready), .config_paulse(paulse_o[i]), .config_data(cdata_o[i]),
      .wr_ready(wr_ready), .wr_req(wr_req_o[i]), .wr_data(wr_data_o[i]),
      .grant(grant_o[i]), .busy(busy_o[i])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, ".busy"}, busy_o[sel], 0);
    check({tag, ".grant"}, grant_o[sel], 0);
    check({tag, ".paulse"}, paulse_o[sel], 0);
    check({tag, ".wr_req"}, wr_req_o[sel], 0);
    check({tag, ".done"}, flg_done_o[sel] | ofm_done_o[sel], 0);
    check({tag, ".ready"}, flg_ready_o[sel] | ofm_ready_o[sel], 0);
  endtask
  task automatic idle_cycle(input logic fr, input logic orq);
    step();
    flg_req = fr;
    ofm_req = orq;
    config_ready = 1'b1;
    flg_valid = 1'b1;
    ofm_valid = 1'b1;
    wr_ready = 1'b1;
    #1;
    check_idle("idle");
  endtask
  task automatic run_pkt(input int arm_wait, input int close_wait, input bit noise, input int abort_at);
    int src, size, n, guard;
    logic r;
    src = (flg_req && ofm_req) ? 1 - last_src : (flg_req ? 0 : 1);
    size = src == 1 ? osz[sel] : fsz[sel];
    step();
    #1;
    check("cfg.paulse", paulse_o[sel], 1);
    check("cfg.code", cdata_o[sel], src == 1 ? 1 : 0);
    check("cfg.grant", grant_o[sel], src == 1 ? 2 : 1);
    check("cfg.busy", busy_o[sel], 1);
    for (int k = 0; k <= arm_wait; k++) begin
      step();
      flg_valid = 1'b1;
      ofm_valid = 1'b1;
      wr_ready = 1'b1;
      config_ready = k < arm_wait;
      if (noise && src == 1) flg_req = 1'($urandom);
      if (noise && src == 0) ofm_req = 1'($urandom);
      #1;
      check("arm.paulse", paulse_o[sel], 0);
      check("arm.wr_req", wr_req_o[sel], 0);
      check("arm.ready", flg_ready_o[sel] | ofm_ready_o[sel], 0);
      check("arm.grant", grant_o[sel], src == 1 ? 2 : 1);
    end
    n = 0;
    guard = 0;
    while (n < size && guard < 200) begin
      step();
      flg_valid = ($urandom % 4) != 0;
      ofm_valid = ($urandom % 4) != 0;
      wr_ready = ($urandom % 4) != 0;
      config_ready = 1'($urandom);
      flg_data = $urandom;
      ofm_data = $urandom;
      if (noise && src == 1) flg_req = 1'($urandom);
      if (noise && src == 0) ofm_req = 1'($urandom);
      #1;
      r = (src == 1 ? ofm_valid : flg_valid) & wr_ready;
      check("str.wr_req", wr_req_o[sel], r);
      check("str.wr_data", wr_data_o[sel], src == 1 ? ofm_data : flg_data);
      check("str.flg_ready", flg_ready_o[sel], (src == 0) & wr_ready);
      check("str.ofm_ready", ofm_ready_o[sel], (src == 1) & wr_ready);
      check("str.done", flg_done_o[sel] | ofm_done_o[sel], 0);
      if (r) n++;
      guard++;
      if (abort_at >= 0 && n == abort_at) return;
    end
    if (n < size) check("str.timeout", n, size);
    for (int k = 0; k < close_wait; k++) begin
      step();
      flg_valid = 1'b1;
      ofm_valid = 1'b1;
      wr_ready = 1'b1;
      config_ready = 1'b0;
      #1;
      check("close.wr_req", wr_req_o[sel], 0);
      check("close.ready", flg_ready_o[sel] | ofm_ready_o[sel], 0);
      check("close.done", flg_done_o[sel] | ofm_done_o[sel], 0);
      check("close.busy", busy_o[sel], 1);
      check("close.code", cdata_o[sel], src == 1 ? 1 : 0);
    end
    step();
    config_ready = 1'b1;
    #1;
    check("done.wr_req", wr_req_o[sel], 0);
    check("done.flg", flg_done_o[sel], src == 0);
    check("done.ofm", ofm_done_o[sel], src == 1);
    check("done.grant", grant_o[sel], src == 1 ? 2 : 1);
    last_src = src;
  endtask
  task automatic random_pkts(input int count);
    logic fr, orq;
    repeat (count) begin
      fr = 1'($urandom);
      orq = fr ? 1'($urandom) : 1'b1;
      idle_cycle(fr, orq);
      run_pkt($urandom_range(0, 3), $urandom_range(1, 3), 1'b1, -1);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    flg_req = 1'b1;
    config_ready = 1'b0;
    #1;
    check_idle("reset");
    check("reset.code", cdata_o[sel], 0);
    rst = 1'b0;
    step();
    #1;
    check_idle("stall");
    idle_cycle(1'b1, 1'b0);
    run_pkt(2, 2, 1'b0, -1);
    repeat (3) begin
      idle_cycle(1'b1, 1'b1);
      run_pkt(1, 1, 1'b0, -1);
    end
    idle_cycle(1'b0, 1'b1);
    run_pkt(5, 1, 1'b0, -1);
    random_pkts(8);
    idle_cycle(1'b1, 1'b0);
    run_pkt(0, 1, 1'b0, 2);
    step();
    rst = 1'b1;
    flg_req = 1'b0;
    step();
    #1;
    check_idle("abort");
    check("abort.code", cdata_o[sel], 0);
    last_src = 1;
    rst = 1'b0;
    step();
    #1;
    check_idle("post_abort");
    idle_cycle(1'b1, 1'b1);
    run_pkt(1, 1, 1'b0, -1);
    sel = 1;
    step();
    rst = 1'b1;
    flg_req = 1'b0;
    ofm_req = 1'b0;
    step();
    #1;
    check_idle("reset1");
    rst = 1'b0;
    last_src = 1;
    idle_cycle(1'b1, 1'b0);
    run_pkt(0, 3, 1'b0, -1);
    idle_cycle(1'b1, 1'b1);
    run_pkt(1, 1, 1'b0, -1);
    random_pkts(4);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
